// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: classify, shift-add multiply, normalize.
// Denormals flush to zero, rounding truncates toward zero.
// Optional status flags output is built only when FP_MUL_SEQ_FLAGS_EN is defined.
module fp_mul_seq #(
  parameter int unsigned N_BIT   = 32,
  parameter int unsigned EXP_BIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BIT-1:0] a,
  input  logic [N_BIT-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N_BIT-1:0] result,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FP_MUL_SEQ_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int unsigned MAN_BIT = N_BIT - EXP_BIT - 1;
  localparam int unsigned PW      = 2 * MAN_BIT + 2;
  localparam int unsigned EW      = EXP_BIT + 2;
  localparam int unsigned CW      = $clog2(MAN_BIT + 1);

  localparam logic signed [EW-1:0] BIAS    = EW'((2 ** (EXP_BIT - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** EXP_BIT) - 1);
  localparam logic [CW-1:0]        LAST    = CW'(MAN_BIT);

  localparam logic [N_BIT-1:0] CANON_NAN = {1'b0, {EXP_BIT{1'b1}}, 1'b1, {(MAN_BIT-1){1'b0}}};

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLASSIFY = 3'd1;
  localparam logic [2:0] ST_MUL      = 3'd2;
  localparam logic [2:0] ST_NORM     = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [N_BIT-1:0]   r_a;
  logic [N_BIT-1:0]   r_b;
  logic [N_BIT-1:0]   r_result;
  logic [PW-1:0]      r_prod;
  logic [PW-1:0]      r_mcand;
  logic [MAN_BIT:0]   r_mplier;
  logic [CW-1:0]      r_cnt;

  // Operand fields and classification of the captured operands
  logic               w_sa, w_sb, w_sign;
  logic [EXP_BIT-1:0] w_ea, w_eb;
  logic [MAN_BIT-1:0] w_ma, w_mb;
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic               w_nan, w_inf, w_zero, w_special;

  assign w_sa = r_a[N_BIT-1];
  assign w_sb = r_b[N_BIT-1];
  assign w_ea = r_a[N_BIT-2 -: EXP_BIT];
  assign w_eb = r_b[N_BIT-2 -: EXP_BIT];
  assign w_ma = r_a[MAN_BIT-1:0];
  assign w_mb = r_b[MAN_BIT-1:0];
  assign w_sign = w_sa ^ w_sb;

  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_nan  = (&w_ea) && (|w_ma);
  assign w_b_nan  = (&w_eb) && (|w_mb);
  assign w_a_inf  = (&w_ea) && !(|w_ma);
  assign w_b_inf  = (&w_eb) && !(|w_mb);

  // Priority: NaN (incl. Inf*0) over Inf over zero
  assign w_nan     = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
  assign w_inf     = w_a_inf || w_b_inf;
  assign w_zero    = w_a_zero || w_b_zero;
  assign w_special = w_nan || w_inf || w_zero;

  // Normalization of the finished product
  logic signed [EW-1:0] w_e_sum, w_e_norm;
  logic [MAN_BIT-1:0]   w_man;
  logic                 w_ovf, w_unf;

  assign w_e_sum  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - BIAS;
  assign w_e_norm = w_e_sum + $signed({{(EW-1){1'b0}}, r_prod[PW-1]});
  assign w_man    = r_prod[PW-1] ? r_prod[PW-2 -: MAN_BIT] : r_prod[PW-3 -: MAN_BIT];
  assign w_ovf    = (w_e_norm >= EXP_MAX);
  assign w_unf    = (w_e_norm <= $signed({EW{1'b0}}));

`ifdef FP_MUL_SEQ_FLAGS_EN
  logic [3:0] r_flags;
  logic       w_dropped;
  assign w_dropped = r_prod[PW-1] ? (|r_prod[MAN_BIT:0]) : (|r_prod[MAN_BIT-1:0]);
  assign flags     = r_flags;
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (in_valid) w_state_nxt = ST_CLASSIFY;
      ST_CLASSIFY: w_state_nxt = w_special ? ST_DONE : ST_MUL;
      ST_MUL:      if (r_cnt == LAST) w_state_nxt = ST_NORM;
      ST_NORM:     w_state_nxt = ST_DONE;
      ST_DONE:     if (out_ready) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath: capture, special-case resolution, shift-add multiply, normalize
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
`ifdef FP_MUL_SEQ_FLAGS_EN
      r_flags  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
`ifdef FP_MUL_SEQ_FLAGS_EN
            r_flags <= '0;
`endif
          end
        end
        ST_CLASSIFY: begin
          if (w_nan) begin
            r_result <= CANON_NAN;
`ifdef FP_MUL_SEQ_FLAGS_EN
            r_flags  <= 4'b1000;
`endif
          end else if (w_inf) begin
            r_result <= {w_sign, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
          end else if (w_zero) begin
            r_result <= {w_sign, {(N_BIT-1){1'b0}}};
          end else begin
            r_mcand  <= {{(PW-MAN_BIT-1){1'b0}}, 1'b1, w_ma};
            r_mplier <= {1'b1, w_mb};
            r_prod   <= '0;
            r_cnt    <= '0;
          end
        end
        ST_MUL: begin
          // One multiplier bit per cycle, LSB first
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        ST_NORM: begin
          if (w_ovf) begin
            r_result <= {w_sign, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
`ifdef FP_MUL_SEQ_FLAGS_EN
            r_flags  <= 4'b0100;
`endif
          end else if (w_unf) begin
            r_result <= {w_sign, {(N_BIT-1){1'b0}}};
`ifdef FP_MUL_SEQ_FLAGS_EN
            r_flags  <= 4'b0010;
`endif
          end else begin
            r_result <= {w_sign, w_e_norm[EXP_BIT-1:0], w_man};
`ifdef FP_MUL_SEQ_FLAGS_EN
            r_flags  <= {3'b000, w_dropped};
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Randomized self-checking bench for fp_mul_seq (default 32-bit parameters).
// A behavioural model computes the expected product from integer arithmetic;
// one negedge process compares every valid output cycle against it.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef FP_MUL_SEQ_FLAGS_EN
  logic [3:0]  flags;
`endif

  fp_mul_seq #(.N_BIT(32), .EXP_BIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FP_MUL_SEQ_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  bit   seen_valid = 0;
  bit   chk_ready_next = 0;
  bit   hold_low = 0;
  bit   rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    else n_pass++;
  endtask

  // Reference: IEEE-style multiply with flush-to-zero and truncation
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    logic        s;
    int          ex, ey, e, sh;
    logic [63:0] mx, my, p, man, drop;
    bit          xnan, ynan, xinf, yinf, xzero, yzero;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = {41'b0, x[22:0]};
    my = {41'b0, y[22:0]};
    xnan = (ex == 255) && (mx != 0);
    ynan = (ey == 255) && (my != 0);
    xinf = (ex == 255) && (mx == 0);
    yinf = (ey == 255) && (my == 0);
    xzero = (ex == 0);
    yzero = (ey == 0);
    f = 4'b0000;
    lat = 2;
    if (xnan || ynan || (xinf && yzero) || (yinf && xzero)) begin
      r = 32'h7FC0_0000;
      f = 4'b1000;
    end else if (xinf || yinf) begin
      r = {s, 8'hFF, 23'h0};
    end else if (xzero || yzero) begin
      r = {s, 31'h0};
    end else begin
      lat = 27;
      p  = ((64'd1 << 23) | mx) * ((64'd1 << 23) | my);
      e  = ex + ey - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e  = e + 1;
      end
      man  = p >> sh;
      drop = p & ((64'd1 << sh) - 1);
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 4'b0100;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 4'b0010;
      end else begin
        r = {s, e[7:0], man[22:0]};
        f = {3'b000, drop != 0};
      end
    end
  endfunction

  // Compare process: reset state, every valid output cycle, latency and ready behaviour
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] mr;
    logic [3:0]  mf;
    int          ml;
    if (rst) begin
      exp_q.delete();
      seen_valid = 0;
      chk_ready_next = 0;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
`ifdef FP_MUL_SEQ_FLAGS_EN
      chk("rst_flags", {28'b0, flags}, 32'd0);
`endif
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          e = exp_q[0];
          if (!seen_valid) begin
            chk("latency", 32'(cyc + 1 - hs_cyc), 32'(e.lat));
            seen_valid = 1;
          end
          chk("result", result, e.r);
`ifdef FP_MUL_SEQ_FLAGS_EN
          chk("flags", {28'b0, flags}, {28'b0, e.f});
`endif
          chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            seen_valid = 0;
            chk_ready_next = 1;
          end
        end
      end else if (chk_ready_next) begin
        chk("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
        chk_ready_next = 0;
      end
      if (in_valid && in_ready) begin
        model(a, b, mr, mf, ml);
        e.r = mr;
        e.f = mf;
        e.lat = ml;
        exp_q.push_back(e);
        hs_cyc = cyc + 1;
      end
    end
  end

  // out_ready driver: held low, random, or always high
  always @(posedge clk) begin
    #1;
    if (hold_low)      out_ready = 1'b0;
    else if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    else               out_ready = 1'b1;
  end

  // Called just after a posedge; returns just after the handshake edge
  task automatic send(input logic [31:0] ta, input logic [31:0] tb);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_in_ready", {31'b0, in_ready}, 32'd1);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom();
    b = $urandom();
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  function automatic logic [31:0] rand_op();
    int          sel;
    logic [7:0]  ex;
    logic [22:0] mn;
    sel = $urandom_range(0, 9);
    mn  = 23'($urandom());
    if (sel == 0)      ex = 8'h00;
    else if (sel == 1) begin
      ex = 8'hFF;
      if ($urandom_range(0, 1) == 0) mn = '0;
    end
    else if (sel == 2) ex = 8'($urandom());
    else               ex = 8'(107 + $urandom_range(0, 40));
    return {1'($urandom()), ex, mn};
  endfunction

  initial begin
    logic [31:0] mr;
    logic [3:0]  mf;
    int          ml;
    int          n;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
    chk("out_valid_after_rst", {31'b0, out_valid}, 32'd0);

    // Pin the model with hand-computed values
    model(32'h4000_0000, 32'h4040_0000, mr, mf, ml);
    chk("model_2x3", mr, 32'h40C0_0000);
    chk("model_2x3_lat", 32'(ml), 32'd27);
    model(32'h3FC0_0000, 32'h3FC0_0000, mr, mf, ml);
    chk("model_1p5sq", mr, 32'h4010_0000);
    model(32'h7F80_0000, 32'h0000_0000, mr, mf, ml);
    chk("model_inf_zero", {mr[31:4], mf}, {28'h7FC0_000, 4'b1000});
    model(32'h7F7F_FFFF, 32'h4000_0000, mr, mf, ml);
    chk("model_ovf", {mr[31:4], mf}, {28'h7F80_000, 4'b0100});
    model(32'h0080_0000, 32'h0080_0000, mr, mf, ml);
    chk("model_unf", {mr[31:4], mf}, {28'h0000_000, 4'b0010});

    // Directed vectors through the DUT
    send(32'h4000_0000, 32'h4040_0000); wait_empty("done_2x3");
    send(32'hC000_0000, 32'h3FC0_0000); wait_empty("done_neg");
    send(32'h3FC0_0000, 32'h3FC0_0000); wait_empty("done_norm");
    send(32'h7F80_0000, 32'h0000_0000); wait_empty("done_nan");
    send(32'h7F7F_FFFF, 32'h4000_0000); wait_empty("done_ovf");
    send(32'h0080_0000, 32'h0080_0000); wait_empty("done_unf");
    send(32'hFF80_0000, 32'h4000_0000); wait_empty("done_neg_inf");
    send(32'h8000_0000, 32'h4000_0000); wait_empty("done_neg_zero");
    send(32'h3F80_0001, 32'h3F80_0001); wait_empty("done_inexact");

    // Back-pressure: result held with out_ready low
    hold_low = 1;
    send(32'h4000_0000, 32'h4040_0000);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", {31'b0, out_valid}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    end
    hold_low = 0;
    @(posedge clk); #1;
    wait_empty("done_bp");

    // Reset during MUL discards the operation
    send(32'h4000_0000, 32'h4040_0000);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("in_ready_after_midrst", {31'b0, in_ready}, 32'd1);
    repeat (40) begin
      @(negedge clk);
      chk("midrst_no_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(32'h3FC0_0000, 32'h3FC0_0000); wait_empty("done_after_rst");

    // Randomized operands with random back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 80; i++) begin
      send(rand_op(), rand_op());
      wait_empty("done_rand");
    end
    rand_rdy = 0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
